// File: rtl/vscale_csr_host_bridge.sv
// Host-to-CSR bridge: queues one host CSR request, waits for a free pipeline slot,
// borrows the CSR port for a single cycle and holds the response until consumed.
// Optional WAIT_SLOT timeout is compiled in with `define VSCALE_CSR_BRIDGE_TIMEOUT_EN.
module vscale_csr_host_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  input  logic        csr_slot_free,
  output logic        csr_active,
  output logic        csr_req,
  output logic [11:0] csr_addr,
  output logic [2:0]  csr_cmd,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_illegal_access
);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    ISSUE,
    RESP
  } state_t;

  state_t      state;
  logic [11:0] addr_q;
  logic [2:0]  cmd_q;
  logic [31:0] wdata_q;

`ifdef VSCALE_CSR_BRIDGE_TIMEOUT_EN
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  // Reset is checked here as well so a reset landing on the ISSUE cycle cannot commit.
  assign csr_req = csr_active && !csr_illegal_access && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      csr_active <= 1'b0;
      csr_addr   <= '0;
      csr_cmd    <= '0;
      csr_wdata  <= '0;
      addr_q     <= '0;
      cmd_q      <= '0;
      wdata_q    <= '0;
`ifdef VSCALE_CSR_BRIDGE_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            cmd_q     <= req_cmd;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            // Commands 4..7 all have bit 2 set; anything else is rejected without touching the CSR file.
            if (req_cmd[2]) begin
              state <= WAIT_SLOT;
`ifdef VSCALE_CSR_BRIDGE_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= ERR_ILLEGAL;
            end
          end
        end

        WAIT_SLOT: begin
          if (csr_slot_free) begin
            state      <= ISSUE;
            csr_active <= 1'b1;
            csr_addr   <= addr_q;
            csr_cmd    <= cmd_q;
            csr_wdata  <= wdata_q;
          end
`ifdef VSCALE_CSR_BRIDGE_TIMEOUT_EN
          // Comparing against limit-1 means the busy cycle that would reach the limit times out.
          else if (wait_cnt == TIMEOUT_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        ISSUE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= csr_rdata;
          resp_err   <= csr_illegal_access ? ERR_ILLEGAL : ERR_OK;
          csr_active <= 1'b0;
          csr_addr   <= '0;
          csr_cmd    <= '0;
          csr_wdata  <= '0;
        end

        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          csr_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
